// File: rtl/inst_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package inst_loader_pkg;

  localparam int ADDR_SIZE           = 5;
  localparam int DATA_SIZE           = 32;
  localparam int MEM_LEN             = 32;
  localparam int LOAD_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_CHK = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } load_state_e;

endpackage

// File: rtl/inst_loader_word_packer.sv
// Packs a little-endian byte stream into words; pulses word_valid with the packed word.
module word_packer
  import inst_loader_pkg::*;
#(
  parameter int DATA_SIZE = inst_loader_pkg::DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic                 last_byte,
  output logic                 word_valid,
  output logic [DATA_SIZE-1:0] word
);

  localparam int BPW = DATA_SIZE / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]        cnt;
  logic [DATA_SIZE-1:0] shift_q;
  logic [DATA_SIZE-1:0] shifted;

  // New bytes enter at the top so the first byte ends up least significant.
  assign shifted   = (shift_q >> 8) | (DATA_SIZE'(byte_in) << (DATA_SIZE - 8));
  assign last_byte = (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shift_q <= shifted;
        if (last_byte) begin
          cnt        <= '0;
          word       <= shifted;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream loader: length, data words, XOR checksum; writes instruction memory from address 0.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_SIZE = inst_loader_pkg::ADDR_SIZE,
  parameter int DATA_SIZE = inst_loader_pkg::DATA_SIZE,
  parameter int MEM_LEN   = inst_loader_pkg::MEM_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_byte,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_error,
  output logic [2:0]           dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state and reset, never on in_valid.
  load_state_e          state;
  logic [7:0]           len_q;
  logic [7:0]           xor_q;
  logic [ADDR_SIZE:0]   addr_cnt;
  logic                 hs;
  logic                 data_hs;
  logic                 last_byte;

  assign in_ready  = !reset && (state == IDLE || state == DATA || state == CSUM);
  assign hs        = in_valid && in_ready;
  assign data_hs   = hs && (state == DATA);
  assign dbg_state = state;

  word_packer #(.DATA_SIZE(DATA_SIZE)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (data_hs),
    .byte_in    (in_byte),
    .last_byte  (last_byte),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      xor_q      <= '0;
      addr_cnt   <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          xor_q    <= '0;
          addr_cnt <= '0;
          if (hs) begin
            len_q <= in_byte;
            xor_q <= in_byte;
            busy  <= 1'b1;
            state <= LEN_CHK;
          end
        end
        LEN_CHK: begin
          if (len_q == 8'd0 || 32'(len_q) > 32'(MEM_LEN)) begin
            busy       <= 1'b0;
            load_error <= 1'b1;
            state      <= ERR;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (hs) begin
            xor_q <= xor_q ^ in_byte;
            if (last_byte) begin
              mem_addr <= addr_cnt[ADDR_SIZE-1:0];
              addr_cnt <= addr_cnt + 1'b1;
              if (32'(addr_cnt) + 32'd1 == 32'(len_q)) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (hs) begin
            busy <= 1'b0;
            if (in_byte == xor_q) begin
              load_done <= 1'b1;
              state     <= DONE;
            end else begin
              load_error <= 1'b1;
              state      <= ERR;
            end
          end
        end
        DONE, ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized frame stimulus checked against a byte-level model of the loader protocol.
module tb_inst_loader;

  localparam int ADDR_SIZE = 5;
  localparam int DATA_SIZE = 32;
  localparam int MEM_LEN   = 32;

  typedef logic [7:0] byte_q_t[$];

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_byte = 8'h00;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic                 busy;
  logic                 load_done;
  logic                 load_error;
  logic [2:0]           dbg_state;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [ADDR_SIZE+DATA_SIZE-1:0] exp_q[$];
  logic [DATA_SIZE-1:0] mem_model [MEM_LEN];

  always #5 clk = ~clk;

  inst_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every 4th data byte accepted must produce exactly one write in the following cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [ADDR_SIZE+DATA_SIZE-1:0] e;
      check("mem_we", {63'd0, mem_we}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (mem_we === 1'b1) begin
          check("mem_addr", 64'(mem_addr), 64'(e[ADDR_SIZE+DATA_SIZE-1:DATA_SIZE]));
          check("mem_wdata", 64'(mem_wdata), 64'(e[DATA_SIZE-1:0]));
        end
      end
    end
  end

  function automatic logic [7:0] xor_of(input byte_q_t q, input int cnt);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < cnt; i++) x ^= q[i];
    return x;
  endfunction

  function automatic logic [31:0] pack_le(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
  endfunction

  function automatic byte_q_t make_frame(input int n, input bit bad);
    byte_q_t q;
    logic [7:0] b;
    q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      q.push_back(b);
    end
    b = xor_of(q, q.size());
    if (bad) b ^= 8'($urandom_range(1, 255));
    q.push_back(b);
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'($urandom_range(1));
    in_byte = 8'($urandom);
    exp_q.delete();
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_error", 64'(load_error), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  // Returns just after the rising edge on which the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok, output int cyc);
    bit hs;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 300) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_byte = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_byte = b;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      cyc++;
      if (hs) ok = 1'b1;
    end
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic run_frame(input string tag, input byte_q_t fb, input int gap_pct, input bit partial);
    int n, cyc, total, ndata;
    bit ok, exp_done;
    logic [7:0] x;
    logic [31:0] w;
    n = int'(fb[0]);
    total = 0;
    send_byte(fb[0], gap_pct, ok, cyc);
    total += cyc;
    if (!ok) return;
    x = fb[0];
    if (n == 0 || n > MEM_LEN) begin
      @(negedge clk);
      check({tag, "_err_not_yet"}, 64'(load_error), 64'd0);
      check({tag, "_busy_lenchk"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_load_error"}, 64'(load_error), 64'd1);
      check({tag, "_load_done"}, 64'(load_done), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      in_valid = 1'b1;
      in_byte = 8'($urandom);
      repeat (3) begin
        @(negedge clk);
        check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      return;
    end
    ndata = partial ? fb.size() - 1 : 4 * n;
    for (int i = 0; i < ndata; i++) begin
      send_byte(fb[1+i], gap_pct, ok, cyc);
      total += cyc;
      if (!ok) return;
      x ^= fb[1+i];
      if (i % 4 == 3) begin
        w = pack_le(fb[i-2], fb[i-1], fb[i], fb[i+1]);
        exp_q.push_back({5'(i / 4), w});
        mem_model[i/4] = w;
      end
    end
    if (partial) return;
    send_byte(fb[4*n+1], gap_pct, ok, cyc);
    total += cyc;
    if (!ok) return;
    exp_done = (fb[4*n+1] == x);
    @(negedge clk);
    check({tag, "_load_done"}, 64'(load_done), 64'(exp_done));
    check({tag, "_load_error"}, 64'(load_error), 64'(!exp_done));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    if (gap_pct == 0) check({tag, "_cycles"}, 64'(total), 64'(4 * n + 3));
    in_valid = 1'b1;
    in_byte = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    byte_q_t f;
    byte_q_t f2;

    check("pin_pack", 64'(pack_le(8'h11, 8'h22, 8'h33, 8'h44)), 64'h44332211);

    // N=1, data 13 00 00 00, checksum 0x12
    f.push_back(8'h01); f.push_back(8'h13); f.push_back(8'h00);
    f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h12);
    check("pin_csum", 64'(xor_of(f, 5)), 64'h12);
    do_reset();
    run_frame("n1", f, 0, 1'b0);
    check("pin_word0", 64'(mem_model[0]), 64'h13);
    check("pin_done", 64'(load_done), 64'd1);

    do_reset();
    run_frame("n32_full", make_frame(32, 1'b0), 0, 1'b0);

    f2 = make_frame(2, 1'b0);
    do_reset();
    run_frame("n2_nogap", f2, 0, 1'b0);
    do_reset();
    run_frame("n2_gaps", f2, 50, 1'b0);

    do_reset();
    run_frame("bad_csum", make_frame(1, 1'b1), 0, 1'b0);

    f.delete(); f.push_back(8'h00);
    do_reset();
    run_frame("len0", f, 0, 1'b0);
    f.delete(); f.push_back(8'h21);
    do_reset();
    run_frame("len33", f, 0, 1'b0);

    // Abort an N=3 frame after 6 data bytes, then load a fresh N=1 frame.
    f.delete(); f.push_back(8'h03);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    do_reset();
    run_frame("partial", f, 20, 1'b1);
    do_reset();
    run_frame("after_abort", make_frame(1, 1'b0), 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      run_frame("rand", make_frame($urandom_range(1, MEM_LEN), $urandom_range(3) == 0),
                $urandom_range(0, 60), 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
